// File: rtl/rab_cfg_pkg.sv
// Shared definitions for the RAB slice configuration programmer: slice register
// offsets, AXI write-response encodings, FSM states and the latched command type.
package rab_cfg_pkg;

   // Widest data word and slice index the latched command can hold
   localparam int unsigned CMD_DW_MAX      = 64;
   localparam int unsigned SLICE_IDX_MAX_W = 8;

   // Register offsets inside one slice block
   localparam logic [7:0] REG_START_OFFS  = 8'h00;
   localparam logic [7:0] REG_END_OFFS    = 8'h08;
   localparam logic [7:0] REG_OFFSET_OFFS = 8'h10;
   localparam logic [7:0] REG_FLAGS_OFFS  = 8'h18;

   // Bit position of the slice enable flag inside the FLAGS word
   localparam int unsigned FLAG_EN_BIT = 0;

   // AXI response encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT_B = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Ordered write steps of a full program sequence; invalidate stops after step 0
   typedef enum logic [2:0] {
      WR_FLAGS_CLR = 3'd0,
      WR_START     = 3'd1,
      WR_END       = 3'd2,
      WR_OFFSET    = 3'd3,
      WR_FLAGS_SET = 3'd4
   } wr_step_e;

   typedef struct packed {
      logic                       inval;
      logic [SLICE_IDX_MAX_W-1:0] slice;
      logic [CMD_DW_MAX-1:0]      addr_start;
      logic [CMD_DW_MAX-1:0]      addr_end;
      logic [CMD_DW_MAX-1:0]      addr_offset;
      logic [CMD_DW_MAX-1:0]      flags;
   } slice_cmd_t;

   // Register offset targeted by a given write step
   function automatic logic [7:0] reg_offs(input wr_step_e step);
      logic [7:0] offs;
      case (step)
         WR_FLAGS_CLR: offs = REG_FLAGS_OFFS;
         WR_START:     offs = REG_START_OFFS;
         WR_END:       offs = REG_END_OFFS;
         WR_OFFSET:    offs = REG_OFFSET_OFFS;
         WR_FLAGS_SET: offs = REG_FLAGS_OFFS;
         default:      offs = REG_FLAGS_OFFS;
      endcase
      return offs;
   endfunction

   // Anything other than a plain OKAY aborts the remaining sequence
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      case (resp)
         RESP_OKAY:   err = 1'b0;
         RESP_EXOKAY: err = 1'b1;
         RESP_SLVERR: err = 1'b1;
         RESP_DECERR: err = 1'b1;
         default:     err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/rab_cfg_programmer_if.sv
// AXI-Lite write channels (AW, W, B) between the slice programmer and the RAB
// configuration responder. Read channels are not part of this link.
interface rab_cfg_programmer_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 64
);
   logic [AW-1:0]   aw_addr;
   logic            aw_valid;
   logic            aw_ready;
   logic [DW-1:0]   w_data;
   logic [DW/8-1:0] w_strb;
   logic            w_valid;
   logic            w_ready;
   logic [1:0]      b_resp;
   logic            b_valid;
   logic            b_ready;

   modport master (
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
      input  aw_ready, w_ready, b_resp, b_valid
   );

   modport slave (
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
      output aw_ready, w_ready, b_resp, b_valid
   );
endinterface

// File: rtl/rab_cfg_programmer.sv
// AXI-Lite initiator that programs or invalidates one RAB L1 slice per command.
// A program command writes FLAGS<=0, START, END, OFFSET, FLAGS<=flags; an
// invalidate writes FLAGS<=0 only. One write is outstanding at a time.
module rab_cfg_programmer
   import rab_cfg_pkg::*;
#(
   parameter int unsigned    AW         = 32,
   parameter int unsigned    DW         = 64,
   parameter int unsigned    N_SLICES   = 16,
   parameter logic [AW-1:0]  CFG_BASE   = '0,
   parameter logic [AW-1:0]  SLICE_OFFS = AW'('h20),
   parameter logic [AW-1:0]  SLICE_STR  = AW'('h20),
   localparam int unsigned   SW         = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_inval_i,
   input  logic [SW-1:0] cmd_slice_i,
   input  logic [DW-1:0] cmd_start_i,
   input  logic [DW-1:0] cmd_end_i,
   input  logic [DW-1:0] cmd_offset_i,
   input  logic [DW-1:0] cmd_flags_i,
   output logic          rsp_valid_o,
   output logic          rsp_err_o,
   rab_cfg_programmer_if.master axi
);

   state_e     state_q, state_d;
   slice_cmd_t cmd_q, cmd_d;
   logic [2:0] idx_q, idx_d;
   logic       aw_pend_q, aw_pend_d;
   logic       w_pend_q, w_pend_d;
   logic       err_q, err_d;
   logic       alive_q;

   wr_step_e      step;
   wr_step_e      last_step;
   logic          cmd_bad;
   logic [AW-1:0] slice_base;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   // Ready only once the first clock after reset release has been seen
   assign cmd_ready_o = alive_q && (state_q == ST_IDLE);

   assign step      = wr_step_e'(idx_q);
   assign last_step = cmd_q.inval ? WR_FLAGS_CLR : WR_FLAGS_SET;

   // Commands are rejected without bus traffic when the slice is out of range
   // or a program range is inverted; invalidates ignore the range words.
   assign cmd_bad = ({1'b0, cmd_slice_i} >= (SW+1)'(N_SLICES)) ||
                    (!cmd_inval_i && (cmd_start_i > cmd_end_i));

   assign slice_base = CFG_BASE + SLICE_OFFS + AW'(cmd_q.slice) * SLICE_STR;
   assign wr_addr    = slice_base + AW'(reg_offs(step));

   // Select the data word for the current write step from the latched command
   always_comb begin
      wr_data = '0;
      case (step)
         WR_FLAGS_CLR: wr_data = '0;
         WR_START:     wr_data = cmd_q.addr_start[DW-1:0];
         WR_END:       wr_data = cmd_q.addr_end[DW-1:0];
         WR_OFFSET:    wr_data = cmd_q.addr_offset[DW-1:0];
         WR_FLAGS_SET: wr_data = cmd_q.flags[DW-1:0];
         default:      wr_data = '0;
      endcase
   end

   // Address and data depend only on registered state, so they hold steady
   // for the whole time a handshake is pending.
   assign axi.aw_addr  = wr_addr;
   assign axi.aw_valid = aw_pend_q;
   assign axi.w_data   = wr_data;
   assign axi.w_strb   = '1;
   assign axi.w_valid  = w_pend_q;
   assign axi.b_ready  = (state_q == ST_WAIT_B);

   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_err_o   = rsp_valid_o && err_q;

   // Next-state logic: command latch, write sequencing and channel handshakes
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      idx_d     = idx_q;
      aw_pend_d = aw_pend_q;
      w_pend_d  = w_pend_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               cmd_d = '{inval:       cmd_inval_i,
                         slice:       SLICE_IDX_MAX_W'(cmd_slice_i),
                         addr_start:  CMD_DW_MAX'(cmd_start_i),
                         addr_end:    CMD_DW_MAX'(cmd_end_i),
                         addr_offset: CMD_DW_MAX'(cmd_offset_i),
                         flags:       CMD_DW_MAX'(cmd_flags_i)};
               idx_d = 3'd0;
               if (cmd_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d     = 1'b0;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  state_d   = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            // AW and W complete independently, in either order or together
            if (aw_pend_q && axi.aw_ready) aw_pend_d = 1'b0;
            if (w_pend_q && axi.w_ready)   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d)   state_d   = ST_WAIT_B;
         end

         ST_WAIT_B: begin
            if (axi.b_valid) begin
               if (resp_is_err(axi.b_resp)) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (step == last_step) begin
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
                  state_d   = ST_ISSUE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and command registers; reset abandons any sequence in flight
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         idx_q     <= 3'd0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         err_q     <= 1'b0;
         alive_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         idx_q     <= idx_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
         err_q     <= err_d;
         alive_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rab_cfg_programmer.sv
// Directed bench for rab_cfg_programmer with an AXI-Lite responder model.
module tb_rab_cfg_programmer;
   import rab_cfg_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned NS = 12;
   localparam int unsigned SW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_inval = 1'b0;
   logic [SW-1:0] cmd_slice = '0;
   logic [DW-1:0] cmd_start = '0;
   logic [DW-1:0] cmd_end = '0;
   logic [DW-1:0] cmd_offset = '0;
   logic [DW-1:0] cmd_flags = '0;
   logic          rsp_valid;
   logic          rsp_err;

   rab_cfg_programmer_if #(.AW(AW), .DW(DW)) axi ();

   rab_cfg_programmer #(
      .AW(AW), .DW(DW), .N_SLICES(NS),
      .CFG_BASE(32'h0), .SLICE_OFFS(32'h20), .SLICE_STR(32'h20)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_inval_i(cmd_inval), .cmd_slice_i(cmd_slice),
      .cmd_start_i(cmd_start), .cmd_end_i(cmd_end),
      .cmd_offset_i(cmd_offset), .cmd_flags_i(cmd_flags),
      .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err),
      .axi(axi)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // responder / monitor state
   logic [AW-1:0] aw_log [64];
   logic [DW-1:0] w_log  [64];
   int   aw_n = 0, w_n = 0, b_n = 0, rsp_n = 0;
   logic rsp_err_last = 1'b0;
   int   stab_err = 0, ost_err = 0, aw_outs = 0;
   int   slv_mode = 0;   // 0: always ready, 1: random stalls
   int   b_lat = 0;
   int   err_aw = -1;    // absolute AW index answered with SLVERR

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Responder: samples handshakes at negedge, drives channel inputs after posedge
   initial begin : responder
      bit aw_got, w_got, b_wait, resp_err_pend, aw_hs, w_hs, b_hs, p_aw_st, p_w_st;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_data;
      int b_cnt;
      aw_got = 0; w_got = 0; b_wait = 0; resp_err_pend = 0;
      p_aw_st = 0; p_w_st = 0; p_addr = '0; p_data = '0; b_cnt = 0;
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = RESP_OKAY;
      forever begin
         @(negedge clk);
         aw_hs = 0; w_hs = 0; b_hs = 0;
         if (!rst_n) begin
            aw_got = 0; w_got = 0; b_wait = 0; resp_err_pend = 0;
            axi.b_valid = 1'b0; aw_outs = 0; p_aw_st = 0; p_w_st = 0;
         end else begin
            if (p_aw_st && !(axi.aw_valid === 1'b1 && axi.aw_addr === p_addr)) stab_err++;
            if (p_w_st && !(axi.w_valid === 1'b1 && axi.w_data === p_data)) stab_err++;
            p_aw_st = (axi.aw_valid === 1'b1) && !axi.aw_ready;
            p_w_st  = (axi.w_valid === 1'b1) && !axi.w_ready;
            p_addr  = axi.aw_addr;
            p_data  = axi.w_data;
            if (axi.aw_valid === 1'b1 && aw_outs > 0) ost_err++;
            aw_hs = (axi.aw_valid === 1'b1) && axi.aw_ready;
            w_hs  = (axi.w_valid === 1'b1) && axi.w_ready;
            b_hs  = axi.b_valid && (axi.b_ready === 1'b1);
            if (aw_hs) begin
               aw_log[aw_n % 64] = axi.aw_addr;
               if (aw_n == err_aw) resp_err_pend = 1;
               aw_n++; aw_outs++; aw_got = 1;
            end
            if (w_hs) begin
               w_log[w_n % 64] = axi.w_data;
               w_n++; w_got = 1;
            end
            if (b_hs) begin
               b_n++; aw_outs--;
            end
            if (rsp_valid === 1'b1) begin
               rsp_n++; rsp_err_last = rsp_err;
            end
         end
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (b_hs) axi.b_valid = 1'b0;
            if (aw_got && w_got) begin
               aw_got = 0; w_got = 0; b_wait = 1;
               b_cnt = (slv_mode == 1) ? int'($urandom_range(0, 3)) : b_lat;
            end
            if (b_wait) begin
               if (b_cnt == 0) begin
                  axi.b_valid = 1'b1;
                  axi.b_resp  = resp_err_pend ? RESP_SLVERR : RESP_OKAY;
                  resp_err_pend = 0; b_wait = 0;
               end else begin
                  b_cnt--;
               end
            end
         end
         axi.aw_ready = (slv_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         axi.w_ready  = (slv_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_cmd(input string tag, input logic inval, input logic [SW-1:0] slice,
                           input logic [DW-1:0] st, input logic [DW-1:0] en,
                           input logic [DW-1:0] off, input logic [DW-1:0] fl);
      int n;
      cmd_valid = 1'b1; cmd_inval = inval; cmd_slice = slice;
      cmd_start = st; cmd_end = en; cmd_offset = off; cmd_flags = fl;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int base, input logic exp_err);
      int n;
      n = 0;
      while (rsp_n == base && n < 2000) begin @(posedge clk); #1; n++; end
      repeat (4) begin @(posedge clk); #1; end
      chk({tag, " rsp_count"}, 64'(rsp_n - base), 64'(1));
      chk({tag, " rsp_err"}, 64'(rsp_err_last), 64'(exp_err));
   endtask

   task automatic check_prog(input string tag, input int ba, input int bw, input logic [AW-1:0] a,
                             input logic [DW-1:0] st, input logic [DW-1:0] en,
                             input logic [DW-1:0] off, input logic [DW-1:0] fl);
      logic [AW-1:0] ea [5];
      logic [DW-1:0] ed [5];
      ea[0] = a + 32'h18; ea[1] = a; ea[2] = a + 32'h8; ea[3] = a + 32'h10; ea[4] = a + 32'h18;
      ed[0] = '0; ed[1] = st; ed[2] = en; ed[3] = off; ed[4] = fl;
      chk({tag, " aw_count"}, 64'(aw_n - ba), 64'(5));
      chk({tag, " w_count"}, 64'(w_n - bw), 64'(5));
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s addr%0d", tag, i), 64'(aw_log[(ba + i) % 64]), 64'(ea[i]));
         chk($sformatf("%s data%0d", tag, i), w_log[(bw + i) % 64], ed[i]);
      end
   endtask

   // Watchdog so the run always terminates
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int ba, bw, br, n;
      logic [DW-1:0] fl_en;
      fl_en = DW'(1) << FLAG_EN_BIT;

      // Reset state
      repeat (3) begin @(posedge clk); #1; end
      chk("rst cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst aw_valid", 64'(axi.aw_valid), 64'(0));
      chk("rst w_valid", 64'(axi.w_valid), 64'(0));
      chk("rst b_ready", 64'(axi.b_ready), 64'(0));
      chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst rsp_err", 64'(rsp_err), 64'(0));
      rst_n = 1'b1;
      chk("release cmd_ready low", 64'(cmd_ready), 64'(0));
      @(posedge clk); #1;
      chk("idle cmd_ready", 64'(cmd_ready), 64'(1));
      chk("w_strb", 64'(axi.w_strb), 64'hFF);

      // T1: program slice 3, no stalls
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t1", 1'b0, 4'd3, 64'h1000, 64'h1FFF, 64'h8000_0000, fl_en);
      wait_rsp("t1", br, 1'b0);
      check_prog("t1", ba, bw, 32'h80, 64'h1000, 64'h1FFF, 64'h8000_0000, 64'h1);
      chk("t1 idle ready", 64'(cmd_ready), 64'(1));

      // T2: invalidate slice 0
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t2", 1'b1, 4'd0, 64'h0, 64'h0, 64'h0, 64'h1);
      wait_rsp("t2", br, 1'b0);
      chk("t2 aw_count", 64'(aw_n - ba), 64'(1));
      chk("t2 addr", 64'(aw_log[ba % 64]), 64'h38);
      chk("t2 data", w_log[bw % 64], 64'h0);

      // Invalidate ignores an inverted range
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("inv_rng", 1'b1, 4'd1, 64'h2000, 64'h1000, 64'h0, 64'h1);
      wait_rsp("inv_rng", br, 1'b0);
      chk("inv_rng aw_count", 64'(aw_n - ba), 64'(1));
      chk("inv_rng addr", 64'(aw_log[ba % 64]), 64'h58);

      // T3: rejected commands
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t3a", 1'b0, 4'(NS), 64'h1000, 64'h1FFF, 64'h0, 64'h1);
      wait_rsp("t3a", br, 1'b1);
      chk("t3a aw_count", 64'(aw_n - ba), 64'(0));
      chk("t3a w_count", 64'(w_n - bw), 64'(0));
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t3b", 1'b0, 4'd2, 64'h2000, 64'h1000, 64'h0, 64'h1);
      wait_rsp("t3b", br, 1'b1);
      chk("t3b aw_count", 64'(aw_n - ba), 64'(0));
      chk("t3b w_count", 64'(w_n - bw), 64'(0));

      // T4: SLVERR on the 2nd write aborts the sequence
      ba = aw_n; bw = w_n; br = rsp_n;
      err_aw = aw_n + 1;
      send_cmd("t4", 1'b0, 4'd4, 64'h100, 64'h200, 64'h300, 64'h1);
      wait_rsp("t4", br, 1'b1);
      err_aw = -1;
      chk("t4 aw_count", 64'(aw_n - ba), 64'(2));
      chk("t4 addr1", 64'(aw_log[(ba + 1) % 64]), 64'hA0);
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t4n", 1'b1, 4'd5, 64'h0, 64'h0, 64'h0, 64'h0);
      wait_rsp("t4n", br, 1'b0);
      chk("t4n addr", 64'(aw_log[ba % 64]), 64'hD8);

      // T5: random stalls on AW, W and B
      slv_mode = 1;
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t5", 1'b0, 4'd3, 64'h1000, 64'h1FFF, 64'h8000_0000, fl_en);
      wait_rsp("t5", br, 1'b0);
      check_prog("t5", ba, bw, 32'h80, 64'h1000, 64'h1FFF, 64'h8000_0000, 64'h1);
      slv_mode = 0;
      chk("t5 stable", 64'(stab_err), 64'(0));
      chk("t5 outstanding", 64'(ost_err), 64'(0));

      // T6: reset during WAIT_B of write 3
      b_lat = 8;
      ba = aw_n; br = rsp_n;
      send_cmd("t6", 1'b0, 4'd3, 64'h1000, 64'h1FFF, 64'h8000_0000, fl_en);
      n = 0;
      while (!(axi.b_ready === 1'b1 && aw_n == ba + 3) && n < 300) begin @(posedge clk); #1; n++; end
      chk("t6 reached wait_b3", 64'(axi.b_ready === 1'b1 && aw_n == ba + 3), 64'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6 cmd_ready", 64'(cmd_ready), 64'(0));
      chk("t6 aw_valid", 64'(axi.aw_valid), 64'(0));
      chk("t6 w_valid", 64'(axi.w_valid), 64'(0));
      chk("t6 b_ready", 64'(axi.b_ready), 64'(0));
      chk("t6 rsp_valid", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      b_lat = 0;
      chk("t6 release ready low", 64'(cmd_ready), 64'(0));
      @(posedge clk); #1;
      chk("t6 ready", 64'(cmd_ready), 64'(1));
      repeat (3) begin @(posedge clk); #1; end
      chk("t6 no rsp", 64'(rsp_n - br), 64'(0));
      ba = aw_n; bw = w_n; br = rsp_n;
      send_cmd("t6n", 1'b0, 4'd11, 64'hA000, 64'hAFFF, 64'h10, fl_en);
      wait_rsp("t6n", br, 1'b0);
      check_prog("t6n", ba, bw, 32'h180, 64'hA000, 64'hAFFF, 64'h10, 64'h1);
      chk("final outstanding", 64'(ost_err), 64'(0));
      chk("final stable", 64'(stab_err), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
